// File: rtl/serial_frame_tx_pkg.sv
// serial_frame_tx_pkg: shared serial-link definitions
// Holds the frame state encoding and a frame-length helper for use by the
// transmitter, the receiver and the benches.
package serial_frame_tx_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Frame length in clock cycles: start + data + optional parity + stop.
    function automatic int frame_len(input int data_width, input int clks_per_bit, input int parity_en);
        return (2 + data_width + parity_en) * clks_per_bit;
    endfunction
endpackage

// File: rtl/serial_frame_tx_baud.sv
// baud_tick_gen: bit-period counter for the serial transmitter
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous reset, active-high
//   clear in   restart the count at zero
//   tick  out  high on the last cycle of each bit period
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    logic [CW-1:0] cnt;
    // With CLKS_PER_BIT=1 the counter stays at zero and every cycle ticks.
    assign tick = cnt == CW'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else     cnt <= (clear || tick) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: serial line transmitter (start, data LSB first, optional parity, stop)
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   data_in    in   word to send, sampled only on accept
//   valid_in   in   data_in is valid
//   ready_out  out  block can accept a word (high only in IDLE)
//   tx_out     out  serial line, idle high
//   busy       out  frame in progress
//   done       out  one-cycle pulse at frame end
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  done
);
    localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic [IW-1:0]         idx, idx_n;
    logic                  par, par_n, tx_n, done_n, tick;
    // Counter is held at zero while idle so the start bit gets a full period.
    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(state == IDLE),
        .tick (tick)
    );
    // Outputs are computed for the next state and registered alongside it.
    always_comb begin
        state_n = state;
        shift_n = shift;
        idx_n   = idx;
        par_n   = par;
        tx_n    = tx_out;
        done_n  = 1'b0;
        case (state)
            IDLE: if (valid_in) begin
                state_n = START;
                shift_n = data_in;
                par_n   = ^data_in ^ (PARITY_ODD != 0);
                idx_n   = '0;
                tx_n    = 1'b0;
            end
            START: if (tick) begin
                state_n = DATA;
                tx_n    = shift[0];
            end
            DATA: if (tick) begin
                if (idx == IW'(DATA_WIDTH - 1)) begin
                    state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    tx_n    = (PARITY_EN != 0) ? par : 1'b1;
                end else begin
                    shift_n = shift >> 1;
                    idx_n   = idx + IW'(1);
                    tx_n    = shift_n[0];
                end
            end
            PARITY: if (tick) begin
                state_n = STOP;
                tx_n    = 1'b1;
            end
            STOP: if (tick) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift     <= '0;
            idx       <= '0;
            par       <= 1'b0;
            tx_out    <= 1'b1;
            done      <= 1'b0;
            ready_out <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            idx       <= idx_n;
            par       <= par_n;
            tx_out    <= tx_n;
            done      <= done_n;
            ready_out <= state_n == IDLE;
            busy      <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: randomized self-checking bench for serial_frame_tx
// Four instances: 0 even parity, 1 odd parity, 2 no parity (all 4 clks/bit), 3 even parity at 1 clk/bit.
module tb_serial_frame_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data [4];
    logic [3:0] valid, tx, rdy, busy, done;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_frame_tx #(
            .DATA_WIDTH  (8),
            .CLKS_PER_BIT(g == 3 ? 1 : 4),
            .PARITY_EN   (g == 2 ? 0 : 1),
            .PARITY_ODD  (g == 1 ? 1 : 0)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .data_in  (data[g]),
            .valid_in (valid[g]),
            .ready_out(rdy[g]),
            .tx_out   (tx[g]),
            .busy     (busy[g]),
            .done     (done[g])
        );
    end

    function automatic int cpb(input int g); return g == 3 ? 1 : 4; endfunction
    function automatic bit pe(input int g);  return g != 2;         endfunction
    function automatic bit po(input int g);  return g == 1;         endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sends one word on instance g and checks every line cycle against the frame
    // built from the line rules. hold keeps valid high into the next frame with nxt;
    // inj scribbles valid/data during the frame; abort_at >= 0 resets at that cycle.
    task automatic send(input int g, input logic [7:0] w, input bit hold,
                        input logic [7:0] nxt, input bit inj, input int abort_at);
        bit q[$];
        int c, len;
        logic [7:0] rx;
        bit last;
        c = cpb(g);
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(w[i]);
        if (pe(g)) q.push_back((^w) ^ po(g));
        q.push_back(1'b1);
        len = q.size() * c;
        chk($sformatf("rdy_pre%0d", g), rdy[g], 1);
        data[g]  = w;
        valid[g] = 1'b1;
        @(posedge clk); #1;
        valid[g] = 1'b0;
        rx = '0;
        for (int k = 0; k < len; k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_tx", tx[g], 1);
                chk("abort_busy", busy[g], 0);
                chk("abort_rdy", rdy[g], 1);
                chk("abort_done", done[g], 0);
                @(posedge clk); #1;
                chk("abort_done2", done[g], 0);
                chk("abort_tx2", tx[g], 1);
                rst = 1'b0;
                return;
            end
            chk($sformatf("tx%0d_k%0d", g, k), tx[g], q[k/c]);
            chk("busy", busy[g], 1);
            chk("rdy", rdy[g], 0);
            chk("done_lo", done[g], 0);
            if (k % c == c / 2 && k / c >= 1 && k / c <= 8) rx[k/c-1] = tx[g];
            last     = k == len - 1;
            valid[g] = last ? hold : (inj ? 1'($urandom % 2) : 1'b0);
            data[g]  = (last && hold) ? nxt : (inj ? 8'($urandom) : w);
            @(posedge clk); #1;
        end
        chk($sformatf("done%0d", g), done[g], 1);
        chk("end_tx", tx[g], 1);
        chk("end_rdy", rdy[g], 1);
        chk("end_busy", busy[g], 0);
        chk("rx_word", rx, w);
        if (!hold) begin
            @(posedge clk); #1;
            chk("done_pulse", done[g], 0);
            chk("idle_tx", tx[g], 1);
        end
    endtask

    initial begin
        int g;
        logic [7:0] w, w2;
        valid = '0;
        for (int i = 0; i < 4; i++) data[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_tx", tx[i], 1);
            chk("rst_rdy", rdy[i], 1);
            chk("rst_busy", busy[i], 0);
            chk("rst_done", done[i], 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        send(0, 8'hA5, 0, 8'h00, 0, -1);
        send(1, 8'h00, 0, 8'h00, 0, -1);
        send(2, 8'hFF, 0, 8'h00, 0, -1);
        send(0, 8'h3C, 1, 8'hC3, 0, -1);
        send(0, 8'hC3, 0, 8'h00, 0, -1);
        send(0, 8'h96, 0, 8'h00, 1, -1);
        send(0, 8'hE7, 0, 8'h00, 0, 17);
        send(0, 8'h81, 0, 8'h00, 0, -1);
        send(3, 8'h01, 0, 8'h00, 0, -1);
        for (int i = 0; i < 24; i++) begin
            g  = int'($urandom % 4);
            w  = 8'($urandom);
            w2 = 8'($urandom);
            if ($urandom % 2 == 1) begin
                send(g, w, 1, w2, 1'($urandom % 2), -1);
                send(g, w2, 0, 8'h00, 1'($urandom % 2), -1);
            end else begin
                send(g, w, 0, 8'h00, 1'($urandom % 2), -1);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
